nanov_serial_regfile: RTL and testbench
=======================================

# nanov_serial_regfile

Parametrised bit-serial register file for the nanoV core: NUM_REGS architectural registers (x0 hard-wired to zero), each XLEN bits, accessed SER_W bits per clock. It has two serial read ports, one serial write port, optional same-cycle write-to-read forwarding, a stall input, a digit-position counter and a word-aligned parallel debug read. It sits between the serial decoder/ALU and replaces the fixed 1-bit RV32E-only file, so the same core can build as RV32E/RV32I at 1-, 2- or 4-bit datapath width.

## Interface
- NUM_REGS, 16: register count including x0; 16 (RV32E) or 32 (RV32I).
- XLEN, 32: register width in bits.
- SER_W, 1: bits transferred per clock; 1, 2 or 4; must divide XLEN.
- BYPASS, 1: 1 enables combinational write-to-read forwarding.
- AW, $clog2(NUM_REGS): register address width (derived).
- clk  input  1  sole clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  advance: rotate all registers and step the digit counter.
- rs1  input  AW  read port 1 address.
- rs2  input  AW  read port 2 address.
- rd  input  AW  write address.
- wr_en  input  1  write the current digit of rd.
- data_rd  input  SER_W  write digit.
- data_rs1  output  SER_W  current digit of rs1.
- data_rs2  output  SER_W  current digit of rs2.
- digit_idx  output  log2(XLEN/SER_W)  index of the digit currently at the head (0 = LS digit).
- digit_last  output  1  high when digit_idx = XLEN/SER_W-1.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  XLEN  parallel value of dbg_addr; valid only when digit_idx = 0.

## Operation
- Storage: each register r (1..NUM_REGS-1) is an XLEN-bit circular shifter whose head digit is its low SER_W bits. With en=1 every register rotates right by SER_W each clock. The digit leaving the head re-enters at the top, or data_rd replaces it when written. All registers always rotate together, so digit positions stay aligned.
- Digit counter: D = XLEN/SER_W. digit_idx increments mod D on each en=1 cycle and wraps D-1 -> 0. At digit_idx = 0 every register sits unrotated, so dbg_data is the true word.
- Read: data_rsN = head digit of rsN, combinational. rsN = 0 returns 0.
- Write: when en=1, wr_en=1 and rd≠0, the digit re-entering register rd is data_rd instead of its old head digit. rd = 0 is ignored. No other register is affected.
- Forwarding (BYPASS=1): when wr_en=1, rd≠0 and rsN = rd, data_rsN = data_rd in the same cycle, so a result streamed back into its own source reads coherently. With BYPASS=0, data_rsN returns the stored (old) digit.
- Stall: en=0 holds every register, digit_idx and digit_last. Reads remain combinational on the held head digit. wr_en is ignored while en=0.
- Out-of-range addresses (≥ NUM_REGS, possible only when NUM_REGS is not a power of two) read as 0, and writes to them are dropped.
- Reset: rst=1 at a clock edge clears every register to 0 and digit_idx to 0, overriding en/wr_en. A reset mid-word discards the partial write.

## Timing
- Reset values: data_rs1 = data_rs2 = 0, digit_idx = 0, digit_last = 0 (D > 1), dbg_data = 0.
- Read latency: 0 cycles (combinational from rsN and state).
- Write: a digit presented in cycle t is stored at edge t+1. It is readable at the head again D en-cycles later, at the same digit_idx.
- A full word written starting at digit_idx = 0 occupies D en-cycles. It is visible on dbg_data from the next digit_idx = 0 onward.
- Wrap: the cycle after digit_last with en=1 has digit_idx = 0.
- Simultaneous rst and en/wr_en: rst wins.
- Simultaneous read and write of the same register: BYPASS decides the value (see Operation). The stored result is always data_rd.

## Test plan
- Reset: rst for 1 cycle with en=1, then sweep rs1/rs2/dbg_addr over all registers -> every read 0, digit_idx=0.
- SER_W=1, NUM_REGS=16: write x5=0xDEADBEEF LSB-first over 32 en-cycles, then read rs1=5 for 32 cycles -> bits reassemble 0xDEADBEEF, and dbg_data=0xDEADBEEF at digit_idx=0. Other registers stay 0.
- x0 and forwarding: write x0=0xFFFFFFFF -> reads 0. With BYPASS=1, wr_en to x7 with data_rd=1 and rs1=rs2=7 -> data_rs1=data_rs2=1 in the same cycle. With BYPASS=0 -> the old bit.
- Stall: SER_W=4, write x3=0x12345678, and drop en for 5 cycles after digit 3 -> digit_idx holds at 4 and data_rs1 holds its digit. The final word is 0x12345678.
- Reset mid-word: NUM_REGS=32, write x31 with 0xAAAAAAAA to digit 10 (SER_W=1), then assert rst -> x31=0 and digit_idx=0.
- Wrap: SER_W=2 and run 40 en-cycles -> digit_last is high at digit_idx=15 only, and the index wraps to 0.

Source files
------------

// File: rtl/nanov_serial_regfile.sv
// Bit-serial register file: NUM_REGS x XLEN rotating shifters moved SER_W bits per clock, x0 reads zero.
// Reads are combinational (0 cycles); en=0 stalls every register and the digit counter.
module nanov_serial_regfile #(
  parameter int NUM_REGS = 16,
  parameter int XLEN     = 32,
  parameter int SER_W    = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int DW       = ((XLEN / SER_W) > 1) ? $clog2(XLEN / SER_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic             wr_en,
  input  logic [SER_W-1:0] data_rd,
  output logic [SER_W-1:0] data_rs1,
  output logic [SER_W-1:0] data_rs2,
  output logic [DW-1:0]    digit_idx,
  output logic             digit_last,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam int D = XLEN / SER_W;

  logic [XLEN-1:0]  regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]  regs_d [1:NUM_REGS-1];
  logic [DW-1:0]    idx_q;
  logic [DW-1:0]    idx_d;
  logic [SER_W-1:0] head1;
  logic [SER_W-1:0] head2;
  logic             rd_ok;
  logic             fwd1;
  logic             fwd2;

  // Addresses at or above NUM_REGS only exist when NUM_REGS is not a power of two.
  assign rd_ok = (rd != '0) && ({1'b0, rd} < (AW+1)'(NUM_REGS));
  assign fwd1  = (BYPASS != 0) && en && wr_en && rd_ok && (rs1 == rd);
  assign fwd2  = (BYPASS != 0) && en && wr_en && rd_ok && (rs2 == rd);

  always_comb begin
    head1    = '0;
    head2    = '0;
    dbg_data = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rs1 == AW'(r))      head1    = regs_q[r][SER_W-1:0];
      if (rs2 == AW'(r))      head2    = regs_q[r][SER_W-1:0];
      if (dbg_addr == AW'(r)) dbg_data = regs_q[r];
    end
  end

  assign data_rs1   = fwd1 ? data_rd : head1;
  assign data_rs2   = fwd2 ? data_rd : head2;
  assign digit_idx  = idx_q;
  assign digit_last = (idx_q == DW'(D - 1));

  // Every register rotates together so all heads always hold the same digit position.
  always_comb begin
    idx_d = idx_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (en) begin
      idx_d = (idx_q == DW'(D - 1)) ? '0 : idx_q + 1'b1;
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_d[r] = (regs_q[r] >> SER_W)
                  | (XLEN'((wr_en && (rd == AW'(r))) ? data_rd : regs_q[r][SER_W-1:0])
                     << (XLEN - SER_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Drives two configurations (16 regs/1-bit/forwarding, 20 regs/4-bit/no forwarding) against a word-level model.
module tb_nanov_serial_regfile;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  // Instance A: NUM_REGS=16, SER_W=1, BYPASS=1
  logic [3:0]  a_rs1, a_rs2, a_rd, a_dbg;
  logic        a_we, a_din, a_o1, a_o2, a_last;
  logic [4:0]  a_idx;
  logic [31:0] a_dbgd;
  // Instance B: NUM_REGS=20 (addresses 20..31 out of range), SER_W=4, BYPASS=0
  logic [4:0]  b_rs1, b_rs2, b_rd, b_dbg;
  logic        b_we, b_last;
  logic [3:0]  b_din, b_o1, b_o2;
  logic [2:0]  b_idx;
  logic [31:0] b_dbgd;

  nanov_serial_regfile #(.NUM_REGS(16), .XLEN(32), .SER_W(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .wr_en(a_we),
    .data_rd(a_din), .data_rs1(a_o1), .data_rs2(a_o2), .digit_idx(a_idx),
    .digit_last(a_last), .dbg_addr(a_dbg), .dbg_data(a_dbgd));

  nanov_serial_regfile #(.NUM_REGS(20), .XLEN(32), .SER_W(4), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .wr_en(b_we),
    .data_rd(b_din), .data_rs1(b_o1), .data_rs2(b_o2), .digit_idx(b_idx),
    .digit_last(b_last), .dbg_addr(b_dbg), .dbg_data(b_dbgd));

  // Reference model: architectural words plus the digit position currently at the head.
  logic [31:0] ma [16];
  logic [31:0] mb [20];
  int ka, kb;
  int checks = 0, passed = 0, fails = 0;
  logic [31:0] got;

  function automatic logic [31:0] dig(logic [31:0] w, int k, int sw);
    return (w >> (k * sw)) & ((32'd1 << sw) - 1);
  endfunction

  function automatic logic [31:0] put(logic [31:0] w, int k, int sw, logic [31:0] d);
    logic [31:0] m;
    m = ((32'd1 << sw) - 1) << (k * sw);
    return (w & ~m) | ((d << (k * sw)) & m);
  endfunction

  function automatic logic [31:0] exp_a(logic [3:0] addr);
    if (addr == 0) return 32'd0;
    if (en && a_we && a_rd != 0 && a_rd == addr) return {31'd0, a_din};
    return dig(ma[addr], ka, 1);
  endfunction

  function automatic logic [31:0] exp_b(logic [4:0] addr);
    if (addr == 0 || addr >= 20) return 32'd0;
    return dig(mb[addr], kb, 4);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and apply the same inputs to the model.
  task automatic cycle();
    #1;
    if (!rst) begin
      chk("a_rs1", {31'd0, a_o1}, exp_a(a_rs1));
      chk("a_rs2", {31'd0, a_o2}, exp_a(a_rs2));
      chk("a_idx", {27'd0, a_idx}, ka);
      chk("a_last", {31'd0, a_last}, {31'd0, ka == 31});
      chk("b_rs1", {28'd0, b_o1}, exp_b(b_rs1));
      chk("b_rs2", {28'd0, b_o2}, exp_b(b_rs2));
      chk("b_idx", {29'd0, b_idx}, kb);
      chk("b_last", {31'd0, b_last}, {31'd0, kb == 7});
      if (ka == 0) chk("a_dbg", a_dbgd, ma[a_dbg]);
      if (kb == 0) chk("b_dbg", b_dbgd, (b_dbg >= 20) ? 32'd0 : mb[b_dbg]);
    end
    @(posedge clk);
    if (rst) begin
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
      ka = 0;
      kb = 0;
    end else if (en) begin
      if (a_we && a_rd != 0) ma[a_rd] = put(ma[a_rd], ka, 1, {31'd0, a_din});
      if (b_we && b_rd != 0 && b_rd < 20) mb[b_rd] = put(mb[b_rd], kb, 4, {28'd0, b_din});
      ka = (ka + 1) % 32;
      kb = (kb + 1) % 8;
    end
    #1;
  endtask

  initial begin
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
    ka = 0; kb = 0;
    a_rs1 = 0; a_rs2 = 0; a_rd = 5; a_dbg = 0; a_we = 1; a_din = 1;
    b_rs1 = 0; b_rs2 = 0; b_rd = 5; b_dbg = 0; b_we = 1; b_din = 4'hF;

    // Reset with en and wr_en asserted; reset must win.
    rst = 1; en = 1;
    cycle();
    cycle();
    rst = 0; en = 0; a_we = 0; b_we = 0;
    for (int i = 0; i < 32; i++) begin
      a_rs1 = 4'(i); a_rs2 = 4'(15 - i); a_dbg = 4'(i);
      b_rs1 = 5'(i); b_rs2 = 5'(31 - i); b_dbg = 5'(i);
      cycle();
    end
    chk("rst_a_idx", {27'd0, a_idx}, 32'd0);
    chk("rst_b_last", {31'd0, b_last}, 32'd0);

    // x5 <= DEADBEEF on A, x3 <= 12345678 on B, with a 5-cycle stall after digit 3.
    en = 1; a_rd = 5; a_rs1 = 5; a_rs2 = 6; b_rd = 3; b_rs1 = 3; b_rs2 = 4;
    got = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      if (i == 4) begin
        en = 0; a_we = 0; b_we = 0;
        repeat (5) cycle();
        chk("stall_b_idx", {29'd0, b_idx}, 32'd4);
        chk("stall_a_idx", {27'd0, a_idx}, 32'd4);
        en = 1;
      end
      a_we = 1; a_din = got[i];
      b_we = (i < 8); b_din = 4'(32'h12345678 >> (4 * (i % 8)));
      cycle();
    end
    a_we = 0; b_we = 0;
    for (int i = 0; i < 32; i++) begin
      #1 got[i] = a_o1;
      cycle();
    end
    chk("x5_serial", got, 32'hDEADBEEF);
    a_dbg = 5; b_dbg = 3;
    #1;
    chk("x5_dbg", a_dbgd, 32'hDEADBEEF);
    chk("x3_dbg", b_dbgd, 32'h12345678);
    a_dbg = 6;
    #1 chk("x6_untouched", a_dbgd, 32'd0);

    // Writes to x0 are dropped.
    a_rd = 0; a_we = 1; a_din = 1; a_rs1 = 0; b_rd = 0; b_we = 1; b_din = 4'hF; b_rs1 = 0;
    repeat (32) cycle();
    a_we = 0; b_we = 0; a_dbg = 0; b_dbg = 0;
    #1 chk("x0_dbg", a_dbgd, 32'd0);

    // Same-cycle forwarding on A; stored digit on B.
    a_rd = 7; a_rs1 = 7; a_rs2 = 7; a_we = 1; a_din = 1;
    b_rd = 7; b_rs1 = 7; b_rs2 = 7; b_we = 1; b_din = 4'hA;
    #1;
    chk("fwd_a_rs1", {31'd0, a_o1}, 32'd1);
    chk("fwd_a_rs2", {31'd0, a_o2}, 32'd1);
    chk("nofwd_b_rs1", {28'd0, b_o1}, 32'd0);
    cycle();
    a_we = 0; b_we = 0;

    // Mid-word reset: write x15 with AAAAAAAA up to digit 10, then reset.
    for (int i = 0; i < 32 && ka != 0; i++) cycle();
    got = 32'hAAAAAAAA;
    a_rd = 15; a_rs1 = 15;
    for (int i = 0; i <= 10; i++) begin
      a_we = 1; a_din = got[i];
      cycle();
    end
    rst = 1;
    cycle();
    rst = 0; a_we = 0; en = 0; a_dbg = 15;
    #1;
    chk("midrst_x15", a_dbgd, 32'd0);
    chk("midrst_idx", {27'd0, a_idx}, 32'd0);

    // Randomized traffic including stalls, out-of-range addresses and occasional reset.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) < 8);
      a_rd = 4'($urandom); a_we = en && ($urandom_range(0, 1) == 1); a_din = 1'($urandom);
      a_rs1 = ($urandom_range(0, 3) == 0) ? a_rd : 4'($urandom);
      a_rs2 = ($urandom_range(0, 3) == 0) ? a_rd : 4'($urandom);
      a_dbg = 4'($urandom);
      b_rd = 5'($urandom); b_we = en && ($urandom_range(0, 1) == 1); b_din = 4'($urandom);
      b_rs1 = ($urandom_range(0, 3) == 0) ? b_rd : 5'($urandom);
      b_rs2 = 5'($urandom);
      b_dbg = 5'($urandom);
      cycle();
    end
    rst = 0;
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
